// File: rtl/hsv2rgb_pkg.sv
// Shared HSV widths, Q11 scaling and hue constants, plus the per-stage pipeline records.
// The RGB->HSV converter and the S/V adjustment block use the same constants.
package hsv2rgb_pkg;

  localparam int H_W = 9;
  localparam int S_W = 11;
  localparam int V_W = 8;

  localparam logic [11:0] Q11_ONE = 12'd2048;

  localparam logic [H_W-1:0] HUE_60  = 9'd60;
  localparam logic [H_W-1:0] HUE_120 = 9'd120;
  localparam logic [H_W-1:0] HUE_180 = 9'd180;
  localparam logic [H_W-1:0] HUE_240 = 9'd240;
  localparam logic [H_W-1:0] HUE_300 = 9'd300;
  localparam logic [H_W-1:0] HUE_360 = 9'd360;

  // f/60 in Q11 is approximated as (f * 4369) >> 7.
  localparam logic [12:0] RECIP_60    = 13'd4369;
  localparam int          RECIP_SHIFT = 7;

  typedef logic [2:0] sector_t;

  typedef struct packed {
    sector_t        sector;
    logic [5:0]     f;
    logic [S_W-1:0] s;
    logic [V_W-1:0] v;
  } s1_t;

  typedef struct packed {
    sector_t        sector;
    logic [11:0]    fr;
    logic [11:0]    fc;
    logic [S_W-1:0] s;
    logic [V_W-1:0] v;
  } s2_t;

  typedef struct packed {
    sector_t        sector;
    logic [11:0]    kp;
    logic [11:0]    kq;
    logic [11:0]    kt;
    logic [V_W-1:0] v;
  } s3_t;

  typedef struct packed {
    sector_t        sector;
    logic [7:0]     p;
    logic [7:0]     q;
    logic [7:0]     t;
    logic [V_W-1:0] v;
  } s4_t;

endpackage

// File: rtl/delay_rg.sv
// Generic W-bit, D-stage register delay line with asynchronous clear.
module delay_rg #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [D];

  // NOTE: this is a handful of flops, not a RAM, so every stage is cleared on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < D; k++) sr[k] <= '0;
    end else begin
      sr[0] <= d;
      for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
    end
  end

  assign q = sr[D-1];

endmodule

// File: rtl/hsv2rgb_sector.sv
// Combinational hue wrap and sector decode: sector = Hw/60, frac = Hw - 60*sector.
module hsv2rgb_sector
  import hsv2rgb_pkg::*;
(
  input  logic [H_W-1:0] hue,
  output sector_t        sector,
  output logic [5:0]     frac
);

  logic [H_W-1:0] hw;
  logic [H_W-1:0] base;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    hw     = (hue >= HUE_360) ? hue - HUE_360 : hue;
    sector = 3'd0;
    base   = '0;
    if (hw >= HUE_300) begin
      sector = 3'd5;
      base   = HUE_300;
    end else if (hw >= HUE_240) begin
      sector = 3'd4;
      base   = HUE_240;
    end else if (hw >= HUE_180) begin
      sector = 3'd3;
      base   = HUE_180;
    end else if (hw >= HUE_120) begin
      sector = 3'd2;
      base   = HUE_120;
    end else if (hw >= HUE_60) begin
      sector = 3'd1;
      base   = HUE_60;
    end
    frac = 6'(hw - base);
  end

endmodule

// File: rtl/hsv2rgb_pipe.sv
// Five-stage HSV->RGB converter with sideband delayed to match the pixel.
// Build option: define HSV2RGB_ROUND_EN for round-half-up scaling in stage 4.
module hsv2rgb_pipe
  import hsv2rgb_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [H_W-1:0] H_in,
  input  logic [S_W-1:0] S_in,
  input  logic [V_W-1:0] V_in,
  input  logic           de_in,
  input  logic           hsync_in,
  input  logic           vsync_in,
  output logic [7:0]     R_out,
  output logic [7:0]     G_out,
  output logic [7:0]     B_out,
  output logic           de_out,
  output logic           hsync_out,
  output logic           vsync_out
);

  if (LATENCY != 5) begin : g_latency_check
    $error("hsv2rgb_pipe: LATENCY must be 5");
  end

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;
  s4_t s4_q, s4_d;
  logic [7:0] r_d, g_d, b_d;

  sector_t    dec_sector;
  logic [5:0] dec_frac;

  hsv2rgb_sector u_sector (
    .hue    (H_in),
    .sector (dec_sector),
    .frac   (dec_frac)
  );

  // V * k >> 11 with saturation; rounding variant biases by half an LSB first.
  function automatic logic [7:0] scale_sat(input logic [19:0] prod);
    logic [19:0] sum;
    logic [8:0]  res;
`ifdef HSV2RGB_ROUND_EN
    sum = prod + 20'd1024;
`else
    sum = prod;
`endif
    res = 9'(sum >> 11);
    return (res > 9'd255) ? 8'hFF : res[7:0];
  endfunction

  logic [18:0] fr_prod;
  logic [22:0] sfr_prod, sfc_prod;
  logic [19:0] vp_prod, vq_prod, vt_prod;

  always_comb begin
    s1_d.sector = dec_sector;
    s1_d.f      = dec_frac;
    s1_d.s      = S_in;
    s1_d.v      = V_in;

    fr_prod     = 19'(s1_q.f) * 19'(RECIP_60);
    s2_d.sector = s1_q.sector;
    s2_d.fr     = 12'(fr_prod >> RECIP_SHIFT);
    s2_d.fc     = Q11_ONE - s2_d.fr;
    s2_d.s      = s1_q.s;
    s2_d.v      = s1_q.v;

    sfr_prod    = 23'(s2_q.s) * 23'(s2_q.fr);
    sfc_prod    = 23'(s2_q.s) * 23'(s2_q.fc);
    s3_d.sector = s2_q.sector;
    s3_d.kp     = Q11_ONE - 12'(s2_q.s);
    s3_d.kq     = Q11_ONE - 12'(sfr_prod >> 11);
    s3_d.kt     = Q11_ONE - 12'(sfc_prod >> 11);
    s3_d.v      = s2_q.v;

    vp_prod     = 20'(s3_q.v) * 20'(s3_q.kp);
    vq_prod     = 20'(s3_q.v) * 20'(s3_q.kq);
    vt_prod     = 20'(s3_q.v) * 20'(s3_q.kt);
    s4_d.sector = s3_q.sector;
    s4_d.p      = scale_sat(vp_prod);
    s4_d.q      = scale_sat(vq_prod);
    s4_d.t      = scale_sat(vt_prod);
    s4_d.v      = s3_q.v;

    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (s4_q.sector)
      3'd0: begin r_d = s4_q.v; g_d = s4_q.t; b_d = s4_q.p; end
      3'd1: begin r_d = s4_q.q; g_d = s4_q.v; b_d = s4_q.p; end
      3'd2: begin r_d = s4_q.p; g_d = s4_q.v; b_d = s4_q.t; end
      3'd3: begin r_d = s4_q.p; g_d = s4_q.q; b_d = s4_q.v; end
      3'd4: begin r_d = s4_q.t; g_d = s4_q.p; b_d = s4_q.v; end
      3'd5: begin r_d = s4_q.v; g_d = s4_q.p; b_d = s4_q.q; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      s4_q  <= '0;
      R_out <= '0;
      G_out <= '0;
      B_out <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      s4_q  <= s4_d;
      R_out <= r_d;
      G_out <= g_d;
      B_out <= b_d;
    end
  end

  delay_rg #(
    .W (3),
    .D (5)
  ) u_sideband (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({de_in, hsync_in, vsync_in}),
    .q       ({de_out, hsync_out, vsync_out})
  );

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// Table-driven and streamed checks of hsv2rgb_pipe through an expected-result queue.
module tb_hsv2rgb_pipe;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [8:0] H_in = '0;
  logic [10:0] S_in = '0;
  logic [7:0] V_in = '0;
  logic       de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [7:0] R_out, G_out, B_out;
  logic       de_out, hsync_out, vsync_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] r, g, b;
    logic       de, hs, vs;
  } exp_t;

  typedef struct {
    int h, s, v;
    logic [7:0] r, g, b;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  hsv2rgb_pipe #(.LATENCY(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .H_in      (H_in),
    .S_in      (S_in),
    .V_in      (V_in),
    .de_in     (de_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .R_out     (R_out),
    .G_out     (G_out),
    .B_out     (B_out),
    .de_out    (de_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Independent reference: plain integer arithmetic, division for the shifts.
  function automatic int scale(int prod);
    int r;
`ifdef HSV2RGB_ROUND_EN
    r = (prod + 1024) / 2048;
`else
    r = prod / 2048;
`endif
    return (r > 255) ? 255 : r;
  endfunction

  function automatic logic [23:0] model(int h, int s, int v);
    int hw, i, f, fr, fc, p, q, t;
    hw = (h >= 360) ? h - 360 : h;
    i  = hw / 60;
    f  = hw - 60 * i;
    fr = (f * 4369) / 128;
    fc = 2048 - fr;
    p  = scale(v * (2048 - s));
    q  = scale(v * (2048 - (s * fr) / 2048));
    t  = scale(v * (2048 - (s * fc) / 2048));
    case (i)
      0: return {8'(v), 8'(t), 8'(p)};
      1: return {8'(q), 8'(v), 8'(p)};
      2: return {8'(p), 8'(v), 8'(t)};
      3: return {8'(p), 8'(q), 8'(v)};
      4: return {8'(t), 8'(p), 8'(v)};
      default: return {8'(v), 8'(p), 8'(q)};
    endcase
  endfunction

  task automatic push_exp(input logic [23:0] rgb, input logic de, input logic hs, input logic vs);
    exp_t e;
    e.r = rgb[23:16]; e.g = rgb[15:8]; e.b = rgb[7:0];
    e.de = de; e.hs = hs; e.vs = vs;
    sb.push_back(e);
  endtask

  // One pixel per clock; the result of the pixel driven five steps ago is compared.
  task automatic step(input int h, input int s, input int v, input logic de, input logic hs,
                      input logic vs, input logic [23:0] rgb);
    exp_t e;
    @(negedge clk);
    H_in = 9'(h); S_in = 11'(s); V_in = 8'(v);
    de_in = de; hsync_in = hs; vsync_in = vs;
    push_exp(rgb, de, hs, vs);
    @(posedge clk);
    #1;
    if (sb.size() >= 5) begin
      e = sb.pop_front();
      check("rgb", {8'h0, R_out, G_out, B_out}, {8'h0, e.r, e.g, e.b});
      check("sideband", {29'h0, de_out, hsync_out, vsync_out}, {29'h0, e.de, e.hs, e.vs});
    end
  endtask

  // Outputs must clear immediately; afterwards the flushed pipeline emits four zero results.
  task automatic apply_reset();
    H_in = '0; S_in = '0; V_in = '0;
    de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    reset_n = 1'b0;
    #1;
    check("reset_outputs", {5'h0, R_out, G_out, B_out, de_out, hsync_out, vsync_out}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    repeat (4) push_exp(24'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int secs[3];
    int lat;
    logic [23:0] got;

    tbl[0]  = '{0,   2047, 255, 8'd255, 8'd0,   8'd0};
    tbl[1]  = '{120, 2047, 255, 8'd0,   8'd255, 8'd0};
    tbl[2]  = '{240, 2047, 255, 8'd0,   8'd0,   8'd255};
    tbl[3]  = '{60,  2047, 255, 8'd255, 8'd255, 8'd0};
    tbl[4]  = '{30,  2047, 200, 8'd200, 8'd100, 8'd0};
    tbl[5]  = '{200, 0,    77,  8'd77,  8'd77,  8'd77};
    tbl[6]  = '{359, 0,    77,  8'd77,  8'd77,  8'd77};
    tbl[7]  = '{400, 2047, 255, 8'd255, 8'd170, 8'd0};
    tbl[8]  = '{40,  2047, 255, 8'd255, 8'd170, 8'd0};
    tbl[9]  = '{359, 2047, 255, 8'd255, 8'd0,   8'd4};
    tbl[10] = '{180, 1500, 0,   8'd0,   8'd0,   8'd0};
    tbl[11] = '{511, 0,    77,  8'd77,  8'd77,  8'd77};
    tbl[12] = '{300, 2047, 255, 8'd255, 8'd0,   8'd255};

    #3;
    apply_reset();

    // Single pixel: count clocks from the sampling edge to de_out.
    @(negedge clk);
    H_in = 9'd0; S_in = 11'd2047; V_in = 8'd255; de_in = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    @(negedge clk);
    H_in = '0; S_in = '0; V_in = '0; de_in = 1'b0;
    while (!de_out && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd5);
    check("latency_rgb", {8'h0, R_out, G_out, B_out}, 32'h00FF0000);

    apply_reset();
    for (int k = 0; k < 13; k++)
      step(tbl[k].h, tbl[k].s, tbl[k].v, 1'b1, k[0], k[1], {tbl[k].r, tbl[k].g, tbl[k].b});
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1'b0, 1'b0, 1'b0, 24'h0);

    // Alternating sectors 0/3/5 with sideband patterns and a reset mid-stream.
    secs[0] = 0; secs[1] = 3; secs[2] = 5;
    for (int n = 0; n < 40; n++) begin
      int h, s, v;
      logic de, hs, vs;
      h = secs[n % 3] * 60 + int'($urandom_range(0, 59));
      if (h < 152 && (n % 4) == 0) h += 360;
      s = int'($urandom_range(0, 2047));
      v = int'($urandom_range(0, 255));
      de = (n % 5) != 4;
      hs = (n % 7) == 0;
      vs = (n % 11) == 0;
      step(h, s, v, de, hs, vs, model(h, s, v));
      if (n == 20) begin
        #3;
        apply_reset();
      end
    end
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1'b0, 1'b0, 1'b0, model(0, 0, 0));

    got = model(30, 2047, 200);
    check("model_sanity_h30", {8'h0, got}, 32'h00C86400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
